sram_wb_bridge: RTL

//   Front end for the 512x64 SRAM22 macro (sram22_512x64m4w8). Accepts pipelined 64-bit

---
 rtl/sram_wb_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_wb_bridge.sv
// sram_wb_bridge: single-port front end for the 512x64 SRAM22 macro.
// Shares the macro between the Microwatt pipelined Wishbone port and the
// hardware debugger req/ack port. It issues at most one access per cycle,
// with responses one cycle later. The debugger cannot be starved forever.
module sram_wb_bridge #(
   parameter int ADDR_WIDTH   = 9,
   parameter int DBG_MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // Wishbone slave (pipelined)
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [7:0]            wb_sel,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   input  logic [63:0]           wb_dat_i,
   output logic [63:0]           wb_dat_o,
   output logic                  wb_ack,
   output logic                  wb_stall,
   // Debugger port
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [63:0]           dbg_wdata,
   output logic [63:0]           dbg_rdata,
   output logic                  dbg_ack,
   // SRAM macro port
   output logic                  sram_rstb,
   output logic                  sram_ce,
   output logic                  sram_we,
   output logic [7:0]            sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [63:0]           sram_din,
   input  logic [63:0]           sram_dout
);

   localparam int CW = $clog2(DBG_MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(DBG_MAX_WAIT - 1);

   typedef enum logic [1:0] {
      GRANT_IDLE,
      GRANT_WB,
      GRANT_DBG
   } grant_t;

   grant_t          grant;
   logic            wb_req;
   logic            dbg_pend;
   logic            wb_pend;
   logic            dbg_ack_q;
   logic            dbg_rd_q;
   logic            dbg_busy;
   logic [CW-1:0]   wait_cnt;
   logic [63:0]     dbg_hold;

   assign wb_req   = wb_cyc & wb_stb;
   // A held debug request is only eligible again once its previous access has been acked.
   assign dbg_pend = dbg_req & ~dbg_ack_q & ~dbg_busy;

   // The debugger wins when Wishbone is idle, or when it has already waited its maximum.
   always_comb begin
      grant = GRANT_IDLE;
      if (dbg_pend && (!wb_req || wait_cnt == WAIT_LIMIT)) begin
         grant = GRANT_DBG;
      end else if (wb_req) begin
         grant = GRANT_WB;
      end
   end

   // Drive the macro from the granted requester; reset gates off any access.
   always_comb begin
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_wmask = 8'h00;
      sram_addr  = '0;
      sram_din   = 64'h0;
      if (grant == GRANT_DBG) begin
         sram_ce    = ~rst;
         sram_we    = dbg_we & ~rst;
         sram_wmask = 8'hFF;
         sram_addr  = dbg_addr;
         sram_din   = dbg_wdata;
      end else if (grant == GRANT_WB) begin
         sram_ce    = ~rst;
         sram_we    = wb_we & ~rst;
         sram_wmask = wb_sel;
         sram_addr  = wb_adr;
         sram_din   = wb_dat_i;
      end
   end

   // Response tracking, starvation counter and the debug read-data hold register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_pend   <= 1'b0;
         dbg_ack_q <= 1'b0;
         dbg_rd_q  <= 1'b0;
         dbg_busy  <= 1'b0;
         wait_cnt  <= '0;
         dbg_hold  <= 64'h0;
      end else begin
         wb_pend   <= (grant == GRANT_WB);
         dbg_ack_q <= (grant == GRANT_DBG);
         dbg_rd_q  <= (grant == GRANT_DBG) & ~dbg_we;
         if (grant == GRANT_DBG) begin
            dbg_busy <= 1'b1;
         end else if (dbg_ack_q) begin
            dbg_busy <= 1'b0;
         end
         if (!dbg_req || grant == GRANT_DBG) begin
            wait_cnt <= '0;
         end else if (dbg_pend && grant == GRANT_WB && wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (dbg_ack_q && dbg_rd_q) begin
            dbg_hold <= sram_dout;
         end
      end
   end

   assign wb_stall  = wb_req & (grant != GRANT_WB);
   assign wb_ack    = wb_pend & wb_cyc & ~rst;
   assign wb_dat_o  = sram_dout;
   assign dbg_ack   = dbg_ack_q & ~rst;
   assign dbg_rdata = (dbg_ack && dbg_rd_q) ? sram_dout : dbg_hold;
   assign sram_rstb = ~rst;

endmodule
